// File: rtl/k051962_pkg.sv
// Shared constants and pixel type for the K051962 tile layer shifter.
// A pixel is a palette nibble plus a 4-bit colour index; index 0 is transparent.
package k051962_pkg;

    localparam int TILE_W    = 8;
    localparam int TILE_LOG2 = $clog2(TILE_W);
    localparam int DL_DEPTH  = 16;
    localparam int PIX_W     = 8;

    typedef struct packed {
        logic [3:0] pal;
        logic [3:0] idx;
    } pixel_t;

    localparam pixel_t PIX_CLEAR = '0;

    function automatic logic opaque(input pixel_t p);
        return p.idx != 4'd0;
    endfunction

endpackage

// File: rtl/k051962_tile_unpack.sv
// Planar-to-chunky conversion of one 8-pixel tile row, with optional X mirror.
// Output slot n is the pixel that must be written at delay-line offset n.
module tile_unpack
    import k051962_pkg::*;
(
    input  logic [31:0]               rom_d,
    input  logic [7:0]                col,
    input  logic                      flip_x,
    output pixel_t [TILE_W-1:0]       tile
);

    // Only the palette nibble is used here; the flip request is resolved by the caller.
    logic unused_col;
    assign unused_col = ^col[3:0];

    generate
        for (genvar gi = 0; gi < TILE_W; gi++) begin : g_pix
            logic [3:0] fwd;
            logic [3:0] rev;

            // Each plane byte holds pixel 0 in its MSB.
            assign fwd = {rom_d[31-gi], rom_d[23-gi], rom_d[15-gi], rom_d[7-gi]};
            assign rev = {rom_d[24+gi], rom_d[16+gi], rom_d[8+gi], rom_d[gi]};

            assign tile[gi] = {col[7:4], (flip_x ? rev : fwd)};
        end
    endgenerate

endmodule

// File: rtl/k051962_layer_shifter.sv
// Pixel delay line for one K051962 tile plane: tiles are dropped in at a fine-scroll
// offset and shifted out one pixel per CE_PIX through a registered output stage.
module k051962_layer_shifter
    import k051962_pkg::*;
#(
    parameter int FINE_W = 3
) (
    input  logic              clk_24M,
    input  logic              nRES,
    input  logic              CE_PIX,
    input  logic              TILE_LD,
    input  logic [31:0]       ROM_D,
    input  logic [7:0]        COL,
    input  logic [FINE_W-1:0] FINE,
    input  logic              FLIPX_EN,
    input  logic              FLIP_SCREEN,
    input  logic              BLANK,
    output logic [PIX_W-1:0]  PIX,
    output logic              OPQ
);

    localparam int IDX_W = $clog2(DL_DEPTH);

    logic                  flip_x;
    pixel_t [TILE_W-1:0]   tile;
    logic [IDX_W-1:0]      base;

    pixel_t                dl_reg  [DL_DEPTH];
    pixel_t                dl_next [DL_DEPTH];
    pixel_t                pix_reg;
    logic                  opq_reg;

    // Screen flip inverts whatever the per-tile attribute asked for.
    assign flip_x = (COL[0] & FLIPX_EN) ^ FLIP_SCREEN;
    assign base   = IDX_W'(FINE);

    tile_unpack u_tile_unpack (
        .rom_d  (ROM_D),
        .col    (COL),
        .flip_x (flip_x),
        .tile   (tile)
    );

    generate
        for (genvar gi = 0; gi < DL_DEPTH; gi++) begin : g_dl
            pixel_t           shifted;
            logic [IDX_W-1:0] off;
            logic             hit;

            if (gi < DL_DEPTH - 1) begin : g_mid
                assign shifted = dl_reg[gi+1];
            end else begin : g_tail
                assign shifted = PIX_CLEAR;
            end

            // A load claims entries base..base+7; it overrides the shifted value there.
            assign off = IDX_W'(gi) - base;
            assign hit = TILE_LD && (base <= IDX_W'(gi)) && (off < IDX_W'(TILE_W));

            assign dl_next[gi] = hit ? tile[off[TILE_LOG2-1:0]] : shifted;
        end
    endgenerate

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_reg[i] <= PIX_CLEAR;
            end
            pix_reg <= PIX_CLEAR;
            opq_reg <= 1'b0;
        end else if (CE_PIX) begin
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_reg[i] <= dl_next[i];
            end
            // BLANK masks the output only; the line keeps moving underneath.
            pix_reg <= BLANK ? PIX_CLEAR : dl_reg[0];
            opq_reg <= !BLANK && opaque(dl_reg[0]);
        end
    end

    assign PIX = pix_reg;
    assign OPQ = opq_reg;

endmodule
